bicubic_phase_gen: RTL and testbench
====================================

Name: bicubic_phase_gen

Overview:
- Drives the coefficient interface of the bicubic kernel-weight stages (inner and outer taps).
- For every output pixel of a horizontal scale pass it produces:
  - the four clamped source-pixel indices;
  - the Q8 fractional phase;
  - the four Q1.8 tap distances that feed the weight stages.
- Sits between the line-control logic (start pulse plus scale configuration) and the weight/multiply pipeline.
- Output is a valid/ready stream, one beat per output pixel.

Parameters:
IDX_W, 11, width of pixel indices and line widths
FRAC_W, 8, fractional phase bits (Q8; 1.0 = 256)
STEP_W, 16, width of the Q8.8 source step per output pixel
ACC_W, 24, width of the signed position accumulator

Ports:
clk  in  1  system clock
rst  in  1  reset: one clock; reset is synchronous and active-high
start  in  1  one-cycle pulse to begin a line; sampled only in IDLE
src_w  in  IDX_W  source line width in pixels (>=1)
dst_w  in  IDX_W  output line width in pixels
step  in  STEP_W  src/dst ratio in Q8.8 (x2 upscale = 128)
busy  out  1  high from accepted start until the last beat handshakes
done  out  1  one-cycle pulse after the line completes
out_valid  out  1  beat valid
out_ready  in  1  downstream accepts beat
idx_m1, idx_0, idx_p1, idx_p2  out  IDX_W each  source indices for taps -1,0,+1,+2, clamped
frac  out  FRAC_W  fractional phase
dist_m1  out  9  256+frac
dist_0  out  9  frac
dist_p1  out  9  256-frac
dist_p2  out  10  512-frac
last  out  1  beat is output pixel dst_w-1

Behaviour:
- Reset (rst=1 at a clock edge):
  - state IDLE; all outputs 0; accumulator and counters 0.
  - Reset mid-line aborts immediately: no done pulse, and the partial beat is dropped.
- States:
  - IDLE: on start with dst_w!=0:
    - latch src_w, dst_w, step;
    - load pos = max(0, (step>>1) - 128) (centre alignment, signed ACC_W compare);
    - x=0; go to RUN.
    - Config input changes after the start cycle have no effect.
  - IDLE: on start with dst_w==0: go to FIN with no beats.
  - RUN:
    - out_valid=1.
    - Fields are registered and derived from the current pos:
      - i = pos>>8; frac = pos[7:0];
      - idx_m1 = (i==0) ? 0 : i-1;
      - idx_0 = min(i, src_w-1);
      - idx_p1 = min(i+1, src_w-1);
      - idx_p2 = min(i+2, src_w-1).
    - Compute and compare indices at IDX_W+2 bits so they never wrap.
    - On out_valid&&out_ready:
      - if x==dst_w-1, go to FIN;
      - else x++, pos += step, and present the next beat the following cycle.
    - With out_valid&&!out_ready, every output holds stable.
  - FIN: done=1 for exactly one cycle; busy=0; return to IDLE.
- busy is high in RUN. start is ignored whenever the state is not IDLE.
- First beat is valid 1 cycle after the accepted start. Throughput is 1 beat/cycle while out_ready=1.
- Distances are exact integers (no saturation). frac=0 gives dist_p1=256 and dist_p2=512.
- last=1 only on the x==dst_w-1 beat.

Test Plan:
- Upscale x2: src_w=4, dst_w=8, step=128 -> 8 beats.
  - Beat0: idx {0,0,1,2}, frac=0, dists {256,0,256,512}.
  - Beat1: idx {0,0,1,2}, frac=128, dists {384,128,128,384}.
  - Beat7: pos=896, idx {2,3,3,3}, frac=128, last=1.
  - done pulses 1 cycle after beat7's handshake.
- Downscale: src_w=8, dst_w=4, step=512 -> pos0=128.
  - Beat0: idx {0,0,1,2}, frac=128.
  - Beat3: pos=1664, idx {5,6,7,7}.
- Backpressure: hold out_ready=0 for 5 cycles mid-line -> all outputs stable, no beat skipped or repeated; output sequence identical to the out_ready=1 run.
- Edge cases:
  - dst_w=0 -> no out_valid, done one cycle after start.
  - start while busy -> ignored; beat count unchanged.
- Reset at beat 3 of an 8-beat line -> next cycle all outputs 0, IDLE, no done; a fresh start reproduces beat0 exactly.

Source files
------------

// File: rtl/bicubic_phase_gen.sv
// Bicubic phase generator: per output pixel, emits four clamped source
// indices, the Q8 phase and the four tap distances as a valid/ready stream.
module bicubic_phase_gen #(
    parameter int unsigned IDX_W  = 11,
    parameter int unsigned FRAC_W = 8,
    parameter int unsigned STEP_W = 16,
    parameter int unsigned ACC_W  = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [IDX_W-1:0]    src_w,
    input  logic [IDX_W-1:0]    dst_w,
    input  logic [STEP_W-1:0]   step,
    output logic                busy,
    output logic                done,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [IDX_W-1:0]    idx_m1,
    output logic [IDX_W-1:0]    idx_0,
    output logic [IDX_W-1:0]    idx_p1,
    output logic [IDX_W-1:0]    idx_p2,
    output logic [FRAC_W-1:0]   frac,
    output logic [FRAC_W:0]     dist_m1,
    output logic [FRAC_W:0]     dist_0,
    output logic [FRAC_W:0]     dist_p1,
    output logic [FRAC_W+1:0]   dist_p2,
    output logic                last
);
    // Index math runs two bits wider so i+2 and src_w-1 never wrap.
    localparam int unsigned IW  = IDX_W + 2;
    localparam int unsigned ONE = 1 << FRAC_W;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t                    r_state;
    logic [IDX_W-1:0]          r_src, r_dst, r_x;
    logic [STEP_W-1:0]         r_step;
    logic signed [ACC_W-1:0]   r_pos;
    logic                      r_busy, r_done, r_valid, r_last;
    logic [IDX_W-1:0]          r_m1, r_z, r_p1, r_p2;
    logic [FRAC_W-1:0]         r_frac;
    logic [FRAC_W:0]           r_dm1, r_d0, r_dp1;
    logic [FRAC_W+1:0]         r_dp2;

    logic signed [ACC_W-1:0]   w_half, w_pos_init, w_pos;
    logic [IDX_W-1:0]          w_src, w_dst, w_x;
    logic [IW-1:0]             w_i, w_max, w_i1, w_i2;
    logic [IW-1:0]             w_m1, w_z, w_p1, w_p2;
    logic [FRAC_W-1:0]         w_frac;
    logic [FRAC_W:0]           w_dm1, w_d0, w_dp1;
    logic [FRAC_W+1:0]         w_dp2;
    logic                      w_last;

    // Fields of the beat that would be presented next: the first beat while
    // idle, otherwise the beat after the current one.
    always_comb begin
        w_half     = $signed(ACC_W'(step >> 1)) - $signed(ACC_W'(ONE >> 1));
        w_pos_init = (w_half < 0) ? '0 : w_half;
        if (r_state == S_IDLE) begin
            w_pos = w_pos_init;
            w_src = src_w;
            w_dst = dst_w;
            w_x   = '0;
        end else begin
            w_pos = r_pos + $signed(ACC_W'(r_step));
            w_src = r_src;
            w_dst = r_dst;
            w_x   = r_x + IDX_W'(1);
        end
        w_i    = IW'(w_pos[ACC_W-1:FRAC_W]);
        w_frac = w_pos[FRAC_W-1:0];
        w_max  = IW'(w_src) - IW'(1);
        w_i1   = w_i + IW'(1);
        w_i2   = w_i + IW'(2);
        w_m1   = (w_i == '0) ? '0 : w_i - IW'(1);
        w_z    = (w_i  < w_max) ? w_i  : w_max;
        w_p1   = (w_i1 < w_max) ? w_i1 : w_max;
        w_p2   = (w_i2 < w_max) ? w_i2 : w_max;
        w_dm1  = {1'b1, w_frac};
        w_d0   = {1'b0, w_frac};
        w_dp1  = (FRAC_W+1)'(ONE) - (FRAC_W+1)'(w_frac);
        w_dp2  = (FRAC_W+2)'(2 * ONE) - (FRAC_W+2)'(w_frac);
        w_last = (w_x == w_dst - IDX_W'(1));
    end

    // Line FSM with registered beat fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_step  <= '0;
            r_x     <= '0;
            r_pos   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_m1    <= '0;
            r_z     <= '0;
            r_p1    <= '0;
            r_p2    <= '0;
            r_frac  <= '0;
            r_dm1   <= '0;
            r_d0    <= '0;
            r_dp1   <= '0;
            r_dp2   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (dst_w != '0) begin
                            r_src   <= src_w;
                            r_dst   <= dst_w;
                            r_step  <= step;
                            r_pos   <= w_pos_init;
                            r_x     <= '0;
                            r_busy  <= 1'b1;
                            r_valid <= 1'b1;
                            r_last  <= w_last;
                            r_m1    <= IDX_W'(w_m1);
                            r_z     <= IDX_W'(w_z);
                            r_p1    <= IDX_W'(w_p1);
                            r_p2    <= IDX_W'(w_p2);
                            r_frac  <= w_frac;
                            r_dm1   <= w_dm1;
                            r_d0    <= w_d0;
                            r_dp1   <= w_dp1;
                            r_dp2   <= w_dp2;
                            r_state <= S_RUN;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_FIN;
                        end
                    end
                end
                S_RUN: begin
                    if (r_valid && out_ready) begin
                        if (r_last) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_m1    <= '0;
                            r_z     <= '0;
                            r_p1    <= '0;
                            r_p2    <= '0;
                            r_frac  <= '0;
                            r_dm1   <= '0;
                            r_d0    <= '0;
                            r_dp1   <= '0;
                            r_dp2   <= '0;
                            r_state <= S_FIN;
                        end else begin
                            r_x     <= w_x;
                            r_pos   <= w_pos;
                            r_last  <= w_last;
                            r_m1    <= IDX_W'(w_m1);
                            r_z     <= IDX_W'(w_z);
                            r_p1    <= IDX_W'(w_p1);
                            r_p2    <= IDX_W'(w_p2);
                            r_frac  <= w_frac;
                            r_dm1   <= w_dm1;
                            r_d0    <= w_d0;
                            r_dp1   <= w_dp1;
                            r_dp2   <= w_dp2;
                        end
                    end
                end
                S_FIN: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign out_valid = r_valid;
    assign last      = r_last;
    assign idx_m1    = r_m1;
    assign idx_0     = r_z;
    assign idx_p1    = r_p1;
    assign idx_p2    = r_p2;
    assign frac      = r_frac;
    assign dist_m1   = r_dm1;
    assign dist_0    = r_d0;
    assign dist_p1   = r_dp1;
    assign dist_p2   = r_dp2;
endmodule

// File: tb/tb_bicubic_phase_gen.sv
// Directed testbench for bicubic_phase_gen.
module tb_bicubic_phase_gen;
    logic        clk = 1'b0;
    logic        rst, start, out_ready;
    logic [10:0] src_w, dst_w;
    logic [15:0] step;
    logic        busy, done, out_valid, last;
    logic [10:0] idx_m1, idx_0, idx_p1, idx_p2;
    logic [7:0]  frac;
    logic [8:0]  dist_m1, dist_0, dist_p1;
    logic [9:0]  dist_p2;

    int vectors    = 0;
    int miscompares = 0;

    // Per-line capture results
    logic [89:0] sig [0:15];
    logic [89:0] up_sig [0:7];
    int n_beats, done_cyc, done_cnt, last_hs, stall_cmp_bad;

    bicubic_phase_gen dut (
        .clk(clk), .rst(rst), .start(start), .src_w(src_w), .dst_w(dst_w),
        .step(step), .busy(busy), .done(done), .out_valid(out_valid),
        .out_ready(out_ready), .idx_m1(idx_m1), .idx_0(idx_0),
        .idx_p1(idx_p1), .idx_p2(idx_p2), .frac(frac), .dist_m1(dist_m1),
        .dist_0(dist_0), .dist_p1(dist_p1), .dist_p2(dist_p2), .last(last)
    );

    always #5 clk = ~clk;

    function automatic logic [89:0] cur_sig();
        return {idx_m1, idx_0, idx_p1, idx_p2, frac, dist_m1, dist_0, dist_p1, dist_p2, last};
    endfunction

    function automatic logic [89:0] hs(int m1, int z, int p1, int p2, int f,
                                       int dm1, int d0, int dp1, int dp2, int l);
        return {11'(m1), 11'(z), 11'(p1), 11'(p2), 8'(f), 9'(dm1), 9'(d0), 9'(dp1), 10'(dp2), 1'(l)};
    endfunction

    // Reference beat from a source width and Q8 position
    function automatic logic [89:0] exp_sig(int s, int pos, int l);
        int i = pos / 256;
        int f = pos % 256;
        int m1 = (i == 0) ? 0 : i - 1;
        int z  = (i     < s - 1) ? i     : s - 1;
        int p1 = (i + 1 < s - 1) ? i + 1 : s - 1;
        int p2 = (i + 2 < s - 1) ? i + 2 : s - 1;
        return hs(m1, z, p1, p2, f, 256 + f, f, 256 - f, 512 - f, l);
    endfunction

    task automatic step_cyc();
        @(posedge clk); #1;
    endtask

    // Runs one line; config inputs are scrambled after the start cycle.
    task automatic run_line(input int s, input int d, input int st,
                            input int stall_at, input int stall_len, input int poke_at);
        int stall_left;
        logic [89:0] snap;
        n_beats = 0; done_cyc = -1; done_cnt = 0; last_hs = -1; stall_cmp_bad = 0;
        stall_left = stall_len;
        snap = '0;
        step_cyc();
        src_w = 11'(s); dst_w = 11'(d); step = 16'(st); start = 1'b1; out_ready = 1'b1;
        step_cyc();
        start = 1'b0; src_w = 11'd1; dst_w = 11'd3; step = 16'd999;
        for (int cyc = 0; cyc < 200; cyc++) begin
            start = (cyc == poke_at);
            if (n_beats == stall_at && stall_left > 0) begin
                out_ready = 1'b0;
                if (stall_left == stall_len) snap = cur_sig();
                else begin
                    vectors++;
                    if (cur_sig() !== snap || out_valid !== 1'b1) begin
                        miscompares++;
                        $display("FAIL stall_hold cyc %0d: got %h want %h", cyc, cur_sig(), snap);
                    end
                end
                stall_left--;
            end else out_ready = 1'b1;
            if (out_valid && out_ready && n_beats < 16) begin
                sig[n_beats] = cur_sig();
                last_hs = cyc;
                n_beats++;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc > done_cyc + 1) break;
            step_cyc();
        end
        out_ready = 1'b1; start = 1'b0;
        if (stall_len > 0) begin
            vectors++;
            if (sig[stall_at] !== snap) begin
                miscompares++;
                $display("FAIL stall_release: got %h want %h", sig[stall_at], snap);
            end
        end
    endtask

    task automatic chk(input string name, input logic [89:0] got, input logic [89:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; out_ready = 1'b1;
        src_w = '0; dst_w = '0; step = '0;
        step_cyc(); step_cyc();
        rst = 1'b0;
        chk("reset_fields", cur_sig(), '0);
        chk("reset_flags", 90'({busy, done, out_valid}), 90'(0));
    endtask

    task automatic test_upscale();
        run_line(4, 8, 128, -1, 0, -1);
        chk("up_count", 90'(n_beats), 90'(8));
        chk("up_beat0", sig[0], hs(0, 0, 1, 2, 0, 256, 0, 256, 512, 0));
        chk("up_beat1", sig[1], hs(0, 0, 1, 2, 128, 384, 128, 128, 384, 0));
        chk("up_beat7", sig[7], hs(2, 3, 3, 3, 128, 384, 128, 128, 384, 1));
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("up_seq%0d", k), sig[k], exp_sig(4, 128 * k, (k == 7) ? 1 : 0));
            up_sig[k] = sig[k];
        end
        chk("up_done_time", 90'(done_cyc), 90'(last_hs + 1));
        chk("up_done_len", 90'(done_cnt), 90'(1));
        chk("up_idle_busy", 90'(busy), 90'(0));
    endtask

    task automatic test_downscale();
        run_line(8, 4, 512, -1, 0, -1);
        chk("dn_count", 90'(n_beats), 90'(4));
        chk("dn_beat0", sig[0], hs(0, 0, 1, 2, 128, 384, 128, 128, 384, 0));
        chk("dn_beat3", sig[3], hs(5, 6, 7, 7, 128, 384, 128, 128, 384, 1));
        for (int k = 1; k < 3; k++)
            chk($sformatf("dn_seq%0d", k), sig[k], exp_sig(8, 128 + 512 * k, 0));
        chk("dn_done_time", 90'(done_cyc), 90'(last_hs + 1));
    endtask

    task automatic test_backpressure();
        run_line(4, 8, 128, 3, 5, -1);
        chk("bp_count", 90'(n_beats), 90'(8));
        for (int k = 0; k < 8; k++)
            chk($sformatf("bp_seq%0d", k), sig[k], up_sig[k]);
        chk("bp_done_time", 90'(done_cyc), 90'(last_hs + 1));
    endtask

    task automatic test_dst_zero();
        run_line(4, 0, 128, -1, 0, -1);
        chk("zero_count", 90'(n_beats), 90'(0));
        chk("zero_done_time", 90'(done_cyc), 90'(0));
        chk("zero_done_len", 90'(done_cnt), 90'(1));
    endtask

    task automatic test_back_to_back_start();
        run_line(4, 8, 128, -1, 0, 2);
        chk("busy_start_count", 90'(n_beats), 90'(8));
        chk("busy_start_beat7", sig[7], up_sig[7]);
        chk("busy_start_done", 90'(done_cyc), 90'(last_hs + 1));
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int bad = 0;
        step_cyc();
        src_w = 11'd4; dst_w = 11'd8; step = 16'd128; start = 1'b1; out_ready = 1'b1;
        step_cyc();
        start = 1'b0;
        for (int c = 0; c < 20 && n < 3; c++) begin
            if (out_valid && out_ready) n++;
            step_cyc();
        end
        chk("rmid_at_beat3", cur_sig(), exp_sig(4, 384, 0));
        rst = 1'b1;
        step_cyc();
        rst = 1'b0;
        chk("rmid_fields", cur_sig(), '0);
        chk("rmid_flags", 90'({busy, done, out_valid}), 90'(0));
        for (int c = 0; c < 4; c++) begin
            if (done || out_valid) bad++;
            step_cyc();
        end
        chk("rmid_no_done", 90'(bad), 90'(0));
        run_line(4, 8, 128, -1, 0, -1);
        chk("rmid_restart_beat0", sig[0], up_sig[0]);
        chk("rmid_restart_count", 90'(n_beats), 90'(8));
    endtask

    initial begin
        test_reset();
        test_upscale();
        test_downscale();
        test_backpressure();
        test_dst_zero();
        test_back_to_back_start();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
